// File: rtl/ysyx_22050612_ctrl_pkg.sv
// Shared types and constants for the execute-stage sequencer.
package ysyx_22050612_ctrl_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned CAUSE_W = 2;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE     = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = 2'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT  = 2'd3;

  // Decoder attributes held from DECODE until the instruction commits.
  typedef struct packed {
    logic wen;
    logic is_load;
    logic is_store;
  } dec_flags_t;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22050612_exu_ctrl_hs_timer.sv
// Handshake wait counter: cleared outside wait states, counts unacknowledged
// request cycles and flags the cycle in which the limit is reached.
module ysyx_22050612_hs_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current cycle is the LIMIT-th unacknowledged one.
  assign expire_c = en_i && !clr_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ysyx_22050612_exu_ctrl.sv
// Multi-cycle execute sequencer: fetch, decode, execute, optional memory, writeback.
// Optional handshake timeout enabled by defining YSYX_22050612_TIMEOUT_EN.
module ysyx_22050612_exu_ctrl
  import ysyx_22050612_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ifu_req,
  output logic [XLEN-1:0]    ifu_addr,
  input  logic               ifu_ack,
  input  logic [ILEN-1:0]    ifu_inst,
  output logic [ILEN-1:0]    inst_q,
  input  logic               dec_wen,
  input  logic               dec_is_load,
  input  logic               dec_is_store,
  input  logic               dec_illegal,
  input  logic               dec_ebreak,
  input  logic [XLEN-1:0]    exu_dnpc,
  output logic               lsu_req,
  input  logic               lsu_ack,
  output logic               rf_wen,
  output logic [XLEN-1:0]    pc,
  output logic               retire,
  output logic [XLEN-1:0]    instret,
  output logic               halt,
  output logic [CAUSE_W-1:0] trap_cause
);

  state_e             state_q, state_d;
  dec_flags_t         flags_q, flags_d;
  logic [ILEN-1:0]    inst_d;
  logic [XLEN-1:0]    npc_q, npc_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    instret_q, instret_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               ifu_req_q, lsu_req_q, rf_wen_q, retire_q, halt_q;
  logic               ifu_fire_c, lsu_fire_c, timeout_c;

  // Acks count only while the matching request is asserted.
  assign ifu_fire_c = ifu_ack && ifu_req_q;
  assign lsu_fire_c = lsu_ack && lsu_req_q;

`ifdef YSYX_22050612_TIMEOUT_EN
  logic wait_clr, wait_en;

  assign wait_clr = (state_q != S_FETCH) && (state_q != S_MEM);
  assign wait_en  = ((state_q == S_FETCH) && !ifu_fire_c) ||
                    ((state_q == S_MEM) && !lsu_fire_c);

  ysyx_22050612_hs_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_hs_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wait_clr),
    .en_i     (wait_en),
    .expire_c (timeout_c)
  );
`else
  logic unused_timeout;

  assign timeout_c      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    inst_d    = inst_q;
    npc_d     = npc_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    cause_d   = cause_q;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (ifu_fire_c) begin
          inst_d  = ifu_inst;
          state_d = S_DECODE;
        end else if (timeout_c) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_HALT;
        end
      end

      S_DECODE: begin
        flags_d.wen      = dec_wen;
        flags_d.is_load  = dec_is_load;
        flags_d.is_store = dec_is_store;
        if (dec_illegal) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = S_HALT;
        end else if (dec_ebreak) begin
          cause_d = CAUSE_NONE;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        npc_d = exu_dnpc;
        if (pc_misaligned(exu_dnpc)) begin
          cause_d = CAUSE_MISALIGN;
          state_d = S_HALT;
        end else if (flags_q.is_load || flags_q.is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        if (lsu_fire_c) begin
          state_d = S_WB;
        end else if (timeout_c) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_HALT;
        end
      end

      S_WB: begin
        pc_d      = npc_q;
        instret_d = instret_q + XLEN'(1);
        state_d   = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_HALT;
    endcase
  end

  // Strobes and requests are decoded from the next state so they are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      flags_q    <= '0;
      inst_q     <= '0;
      npc_q      <= '0;
      pc_q       <= RESET_PC;
      instret_q  <= '0;
      cause_q    <= CAUSE_NONE;
      ifu_req_q  <= 1'b0;
      lsu_req_q  <= 1'b0;
      rf_wen_q   <= 1'b0;
      retire_q   <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      inst_q     <= inst_d;
      npc_q      <= npc_d;
      pc_q       <= pc_d;
      instret_q  <= instret_d;
      cause_q    <= cause_d;
      ifu_req_q  <= (state_d == S_FETCH);
      lsu_req_q  <= (state_d == S_MEM);
      rf_wen_q   <= (state_d == S_WB) && flags_d.wen && !flags_d.is_store;
      retire_q   <= (state_d == S_WB);
      halt_q     <= (state_d == S_HALT);
    end
  end

  assign ifu_req    = ifu_req_q;
  assign ifu_addr   = pc_q;
  assign lsu_req    = lsu_req_q;
  assign rf_wen     = rf_wen_q;
  assign pc         = pc_q;
  assign retire     = retire_q;
  assign instret    = instret_q;
  assign halt       = halt_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_ysyx_22050612_exu_ctrl.sv
// Scoreboard bench for ysyx_22050612_exu_ctrl; timeout scenario runs when
// YSYX_22050612_TIMEOUT_EN is defined.
module tb_ysyx_22050612_exu_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, ifu_ack;
  logic [63:0] ifu_addr;
  logic [31:0] ifu_inst, inst_q;
  logic        dec_wen, dec_is_load, dec_is_store, dec_illegal, dec_ebreak;
  logic [63:0] exu_dnpc, pc, instret;
  logic        lsu_req, lsu_ack, rf_wen, retire, halt;
  logic [1:0]  trap_cause;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] npc;
    logic [31:0] inst;
    logic        wen;
    logic [63:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        pend_e;
  logic        pend = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_pc = RST_PC;
  logic [63:0] m_cnt = '0;

  always #5 clk = ~clk;

  ysyx_22050612_exu_ctrl #(
    .RESET_PC       (RST_PC),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req      (ifu_req),
    .ifu_addr     (ifu_addr),
    .ifu_ack      (ifu_ack),
    .ifu_inst     (ifu_inst),
    .inst_q       (inst_q),
    .dec_wen      (dec_wen),
    .dec_is_load  (dec_is_load),
    .dec_is_store (dec_is_store),
    .dec_illegal  (dec_illegal),
    .dec_ebreak   (dec_ebreak),
    .exu_dnpc     (exu_dnpc),
    .lsu_req      (lsu_req),
    .lsu_ack      (lsu_ack),
    .rf_wen       (rf_wen),
    .pc           (pc),
    .retire       (retire),
    .instret      (instret),
    .halt         (halt),
    .trap_cause   (trap_cause)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Retire monitor: pops the scoreboard and checks the commit one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pend = 1'b0;
      sb_q.delete();
    end else begin
      if (pend) begin
        check("pc_commit", pc, pend_e.npc);
        check("instret", instret, pend_e.cnt);
        pend = 1'b0;
      end
      if (rf_wen) check("rfwen_pair", 64'(retire), 64'(1));
      if (retire) begin
        if (sb_q.size() == 0) begin
          check("retire_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("rf_wen", 64'(rf_wen), 64'(e.wen));
          check("pc_at_wb", pc, e.pc);
          check("inst_q", 64'(inst_q), 64'(e.inst));
          pend_e = e;
          pend   = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    ifu_ack = 1'b0; lsu_ack = 1'b0; ifu_inst = '0; exu_dnpc = '0;
    dec_wen = 1'b0; dec_is_load = 1'b0; dec_is_store = 1'b0;
    dec_illegal = 1'b0; dec_ebreak = 1'b0;
    @(negedge clk);
    check("rst_pc", pc, RST_PC);
    check("rst_ifu_req", 64'(ifu_req), 64'(0));
    check("rst_lsu_req", 64'(lsu_req), 64'(0));
    check("rst_rf_wen", 64'(rf_wen), 64'(0));
    check("rst_retire", 64'(retire), 64'(0));
    check("rst_instret", instret, 64'(0));
    check("rst_halt", 64'(halt), 64'(0));
    check("rst_cause", 64'(trap_cause), 64'(0));
    m_pc  = RST_PC;
    m_cnt = '0;
    rst   = 1'b0;
  endtask

  task automatic run_inst(input string tag, input logic wen, input logic ld, input logic st,
                          input int delay, input int exp_cyc, input int exp_lreq);
    exp_t        e;
    int          cyc = 0, lreq = 0, wcnt = 0;
    bit          done = 0, seen = 0;
    logic [63:0] dnpc;
    dnpc   = m_pc + 64'd4;
    e.inst = $urandom;
    e.pc   = m_pc;
    e.npc  = dnpc;
    e.wen  = wen & ~st;
    e.cnt  = m_cnt + 64'd1;
    sb_q.push_back(e);
    ifu_inst = e.inst; exu_dnpc = dnpc; ifu_ack = 1'b1;
    dec_wen = wen; dec_is_load = ld; dec_is_store = st;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (ifu_req && !seen) begin
        seen = 1;
        check({tag, "_addr"}, ifu_addr, m_pc);
      end
      if (seen) cyc++;
      if (lsu_req) begin
        lreq++;
        lsu_ack = (lreq == delay + 1);
      end else begin
        lsu_ack = 1'b0;
      end
      if (rf_wen) wcnt++;
      if (retire) done = 1;
    end
    lsu_ack = 1'b0;
    check({tag, "_retired"}, 64'(done), 64'(1));
    check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_lsu_req_cyc"}, 64'(lreq), 64'(exp_lreq));
    check({tag, "_rf_wen_cnt"}, 64'(wcnt), 64'(e.wen));
    m_pc  = dnpc;
    m_cnt = m_cnt + 64'd1;
  endtask

  task automatic expect_halt(input string tag, input logic illegal, input logic ebreak,
                             input logic [63:0] dnpc, input logic ack, input logic [1:0] cause,
                             input int exp_fetch);
    int n = 0, busy = 0, fetch = 0;
    ifu_inst = $urandom; exu_dnpc = dnpc; ifu_ack = ack;
    dec_wen = 1'b1; dec_is_load = 1'b0; dec_is_store = 1'b0;
    dec_illegal = illegal; dec_ebreak = ebreak;
    while (!halt && n < 50) begin
      @(negedge clk);
      if (ifu_req) fetch++;
      n++;
    end
    check({tag, "_halt"}, 64'(halt), 64'(1));
    check({tag, "_cause"}, 64'(trap_cause), 64'(cause));
    check({tag, "_pc_held"}, pc, m_pc);
    check({tag, "_instret_held"}, instret, m_cnt);
    if (exp_fetch >= 0) check({tag, "_fetch_cyc"}, 64'(fetch), 64'(exp_fetch));
    repeat (20) begin
      @(negedge clk);
      if (ifu_req || lsu_req || rf_wen || retire || !halt) busy++;
    end
    check({tag, "_quiet"}, 64'(busy), 64'(0));
    dec_illegal = 1'b0; dec_ebreak = 1'b0; ifu_ack = 1'b0;
  endtask

  initial begin
    do_reset();
    run_inst("addi", 1'b1, 1'b0, 1'b0, 0, 4, 0);
    run_inst("addi2", 1'b1, 1'b0, 1'b0, 0, 4, 0);
    run_inst("load", 1'b1, 1'b1, 1'b0, 3, 8, 4);
    run_inst("store", 1'b0, 1'b0, 1'b1, 0, 5, 1);
    run_inst("store_w", 1'b1, 1'b0, 1'b1, 1, 6, 2);
    run_inst("addi3", 1'b1, 1'b0, 1'b0, 0, 4, 0);
    expect_halt("misalign", 1'b0, 1'b0, 64'h8000_0002, 1'b1, 2'd2, -1);

    do_reset();
    expect_halt("illegal", 1'b1, 1'b1, RST_PC + 64'd4, 1'b1, 2'd1, -1);

    do_reset();
    expect_halt("ebreak", 1'b0, 1'b1, RST_PC + 64'd4, 1'b1, 2'd0, -1);

    // Reset asserted mid-fetch after one commit.
    do_reset();
    run_inst("pre_rst", 1'b1, 1'b0, 1'b0, 0, 4, 0);
    ifu_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("midfetch_req", 64'(ifu_req), 64'(1));
    check("midfetch_addr", ifu_addr, RST_PC + 64'd4);
    #2 rst = 1'b1;
    #1;
    check("async_req_drop", 64'(ifu_req), 64'(0));
    check("async_pc", pc, RST_PC);
    check("async_instret", instret, 64'(0));
    check("async_rf_wen", 64'(rf_wen), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    m_pc = RST_PC;
    m_cnt = '0;
    run_inst("post_rst", 1'b1, 1'b0, 1'b0, 0, 4, 0);

`ifdef YSYX_22050612_TIMEOUT_EN
    do_reset();
    expect_halt("timeout", 1'b0, 1'b0, RST_PC + 64'd4, 1'b0, 2'd3, 4);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_exu_ctrl.md
# ysyx_22050612_exu_ctrl

Multi-cycle sequencer that drives the execute datapath. It fetches one instruction at a time, latches it for the decoder, and waits out the execute step. It performs an optional memory handshake, then issues a single-cycle register-file write strobe and commits the next PC. It sits between the instruction-fetch port, the decoder/EXU datapath and the load/store unit, and it owns `pc`, the retire counter and halt/trap status.

## Interface
- `RESET_PC`, 64'h8000_0000: value loaded into `pc` by reset.
- `TIMEOUT_CYCLES`, 255: wait-cycle limit on fetch/LSU handshakes. Used only with `YSYX_22050612_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ifu_req` out 1: fetch request.
- `ifu_addr` out 64: fetch address, equals `pc`.
- `ifu_ack` in 1: fetch complete, `ifu_inst` valid.
- `ifu_inst` in 32: fetched instruction.
- `inst_q` out 32: latched instruction to decoder/EXU.
- `dec_wen` in 1: instruction writes rd.
- `dec_is_load` in 1: instruction is a load.
- `dec_is_store` in 1: instruction is a store.
- `dec_illegal` in 1: illegal encoding.
- `dec_ebreak` in 1: ebreak.
- `exu_dnpc` in 64: next PC computed by EXU.
- `lsu_req` out 1: memory access request.
- `lsu_ack` in 1: memory access done.
- `rf_wen` out 1: register-file write strobe, one-cycle pulse.
- `pc` out 64: current PC.
- `retire` out 1: one-cycle pulse per committed instruction.
- `instret` out 64: retired-instruction count.
- `halt` out 1: sequencer stopped.
- `trap_cause` out 2: 0 none/ebreak, 1 illegal, 2 misaligned dnpc, 3 timeout.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: held for one cycle after reset release, then moves to FETCH.
- FETCH: `ifu_req`=1 and `ifu_addr`=`pc` held stable until `ifu_ack`. On ack: `inst_q`<=`ifu_inst`, go to DECODE.
- DECODE: latch `dec_wen`/`dec_is_load`/`dec_is_store`.
  - `dec_illegal` → HALT, cause 1. Illegal takes priority over ebreak.
  - `dec_ebreak` → HALT, cause 0.
  - Otherwise → EXEC.
- EXEC: capture `exu_dnpc` into `npc_q`.
  - `exu_dnpc[1:0]`≠0 → HALT, cause 2.
  - Load or store → MEM.
  - Otherwise → WB.
- MEM: `lsu_req`=1 until `lsu_ack`, then go to WB.
- WB: `rf_wen`=latched `dec_wen` (stores write 0), `pc`<=`npc_q`, `retire`=1, `instret`+1 (wraps 2^64−1→0), then go to FETCH.
- HALT: all requests and strobes are 0 and `halt`=1. The state holds until `rst`.
- An ack arriving while its request is low is ignored. An ack in the same cycle the request first rises is accepted.

## Timing
- Every output is registered. All outputs reset to 0, except `pc`, which resets to `RESET_PC`.
- Latency with zero-wait acks:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
- `rf_wen` and `retire` are high for exactly one cycle, in the same WB cycle. `pc` takes its new value on the next edge.
- `rst` asserted mid-handshake drops `ifu_req`/`lsu_req` asynchronously. No partial commit happens: `pc`, `instret` and `rf_wen` return to reset values.

## Configuration
- `YSYX_22050612_TIMEOUT_EN` defined:
  - A wait counter clears on entry to FETCH and to MEM, and increments each cycle the request is unacknowledged.
  - If the counter reaches `TIMEOUT_CYCLES`, go to HALT with cause 3.
  - An ack in that same cycle wins over the timeout.
- Undefined: handshakes wait indefinitely, and cause 3 is never produced.

## Structure
- Package `ysyx_22050612_ctrl_pkg` holds:
  - the state enum (3-bit);
  - the trap-cause constants;
  - the `RESET_PC` default.
- One sub-module, `ysyx_22050612_hs_timer`: the wait counter with clear/enable/expire. It is instantiated only under the macro.

## Test plan
- Reset, then `ifu_ack` tied to 1 with an addi-type instruction (`dec_wen`=1) → `ifu_addr`=0x8000_0000 in cycle 1. `rf_wen`/`retire` pulse in cycle 4. `pc`=0x8000_0004 and `instret`=1 afterward.
- Load with `lsu_ack` delayed 3 cycles → `lsu_req` high for 4 cycles, `rf_wen` pulses once, 8 cycles per instruction in total.
- Store (`dec_wen`=0) → `retire`=1, `rf_wen` stays 0.
- `dec_illegal`=1 together with `dec_ebreak`=1 → `halt`=1 with cause 1. `ifu_req` stays 0 for 20 further cycles.
- `exu_dnpc`=0x8000_0002 → HALT, cause 2, `pc` unchanged.
- With the macro and `TIMEOUT_CYCLES`=4, `ifu_ack` held 0 → HALT cause 3 after 4 wait cycles. `rst` pulsed during a later fetch → `ifu_req` drops in the same cycle and `pc` returns to 0x8000_0000.
